// File: rtl/wb_modport.sv
// -----------------------------------------------------------------------------
// wb_modport -- Wishbone B4 pipelined slave backed by a small register-file
// memory. Every word carries a TAG_W-bit data tag. Byte-lane writes, one
// transfer per cycle, single-cycle registered ack/err responses.
//
// Ports
//   clk            bus clock, rising edge
//   rst_i          asynchronous active-high reset
//   cyc, stb, we   bus cycle, transfer request, write enable
//   adr            byte address (ADR_W)
//   sel            byte lane enables for writes (SEL_W)
//   dat_i, tgd_i   write data and write data tag
//   tga, tgc, lock accepted, no effect
//   dat_o, tgd_o   read data and read data tag (held between reads)
//   ack, err       one-cycle response pulses, never both high
//   rty            constant 0
//   stall          pipeline stall (0 unless WB_STALL_INJECT_EN is defined)
//
// Build option
//   WB_STALL_INJECT_EN : adds a 2-bit counter that advances every clock while
//                        cyc=1; stall is raised whenever it reads 3.
// -----------------------------------------------------------------------------
module wb_modport #(
    parameter int ADR_W  = 32,
    parameter int DAT_W  = 64,
    parameter int TAG_W  = 1,
    parameter int MEM_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic [ADR_W-1:0]     adr,
    input  logic [DAT_W/8-1:0]   sel,
    input  logic [DAT_W-1:0]     dat_i,
    input  logic [TAG_W-1:0]     tgd_i,
    input  logic [TAG_W-1:0]     tga,
    input  logic [TAG_W-1:0]     tgc,
    input  logic                 lock,
    output logic [DAT_W-1:0]     dat_o,
    output logic [TAG_W-1:0]     tgd_o,
    output logic                 ack,
    output logic                 err,
    output logic                 rty,
    output logic                 stall
);

    localparam int SEL_W = DAT_W / 8;
    localparam int B     = $clog2(SEL_W);
    localparam int DEPTH = 2 ** MEM_AW;

    logic [DAT_W-1:0] mem     [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [MEM_AW-1:0] word_idx;
    logic              in_range;
    logic              accept;
    logic              wr_hit;
    logic              rd_hit;
    logic [DAT_W-1:0]  lane_mask;
    logic              ack_reg;
    logic              err_reg;
    logic [DAT_W-1:0]  dat_reg;
    logic [TAG_W-1:0]  tgd_reg;

    // Sub-word address bits and the side-band tags have no function here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, tga, tgc, lock, adr[B-1:0]};

    assign word_idx = adr[B +: MEM_AW];
    assign in_range = ~|adr[ADR_W-1:B+MEM_AW];
    assign accept   = cyc && stb && !stall;
    assign wr_hit   = accept && we && in_range;
    assign rd_hit   = accept && !we && in_range;

    // Expand byte enables into a bit mask so a write is a single masked merge.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{sel[gi]}};
        end
    endgenerate

    // Storage: written at the accept edge, so a read accepted on the very next
    // edge already sees the new contents.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w]     <= '0;
                tag_mem[w] <= '0;
            end
        end else if (wr_hit) begin
            mem[word_idx] <= (mem[word_idx] & ~lane_mask) | (dat_i & lane_mask);
            if (|sel) begin
                tag_mem[word_idx] <= tgd_i;
            end
        end
    end

    // Response and read-data registers. Read data is captured at the accept
    // edge and held until the next in-range read.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            dat_reg <= '0;
            tgd_reg <= '0;
        end else begin
            ack_reg <= accept && in_range;
            err_reg <= accept && !in_range;
            if (rd_hit) begin
                dat_reg <= mem[word_idx];
                tgd_reg <= tag_mem[word_idx];
            end
        end
    end

    // A master that drops cyc in the response cycle has abandoned the cycle,
    // so the pending termination is masked rather than presented.
    assign ack   = ack_reg && cyc;
    assign err   = err_reg && cyc;
    assign dat_o = dat_reg;
    assign tgd_o = tgd_reg;
    assign rty   = 1'b0;

`ifdef WB_STALL_INJECT_EN
    logic [1:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= 2'd0;
        end else if (cyc) begin
            stall_cnt_reg <= stall_cnt_reg + 2'd1;
        end
    end

    assign stall = cyc && (stall_cnt_reg == 2'd3);
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_modport.sv
// -----------------------------------------------------------------------------
// tb_wb_modport -- randomized scoreboard bench for wb_modport.
// The driver issues transfers and, at each accept edge, updates a word-array
// reference model and pushes the expected response. A monitor on the falling
// edge pops one entry per response cycle and compares ack/err/dat_o/tgd_o.
// -----------------------------------------------------------------------------
module tb_wb_modport;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [7:0]  sel = '0;
    logic [63:0] dat_i = '0;
    logic [0:0]  tgd_i = '0;
    logic [0:0]  tga = '0;
    logic [0:0]  tgc = '0;
    logic        lock = 1'b0;
    logic [63:0] dat_o;
    logic [0:0]  tgd_o;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;

    wb_modport dut (
        .clk   (clk),
        .rst_i (rst_i),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .adr   (adr),
        .sel   (sel),
        .dat_i (dat_i),
        .tgd_i (tgd_i),
        .tga   (tga),
        .tgc   (tgc),
        .lock  (lock),
        .dat_o (dat_o),
        .tgd_o (tgd_o),
        .ack   (ack),
        .err   (err),
        .rty   (rty),
        .stall (stall)
    );

    always #5 clk = ~clk;

    // kind: 0 = no response expected, 1 = ack, 2 = err
    typedef struct {
        int          kind;
        bit          rd;
        logic [63:0] dat;
        logic        tg;
        logic [31:0] adr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem_m [16];
    logic        tag_m [16];
    logic [63:0] last_dat;
    logic        last_tg;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int          cyc_count = 0;
    int          n_stalls = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 16; w++) begin
            mem_m[w] = '0;
            tag_m[w] = 1'b0;
        end
        last_dat = '0;
        last_tg  = 1'b0;
    endtask

    // Count of clocks seen with cyc high since reset; stall is due when it is 3 mod 4.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) cyc_count <= 0;
        else if (cyc) cyc_count <= cyc_count + 1;
    end

    // Monitor: one expected entry is consumed per clock that has one queued.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_stall;
`ifdef WB_STALL_INJECT_EN
            exp_stall = cyc && ((cyc_count % 4) == 3);
`else
            exp_stall = 1'b0;
`endif
            check(stall == exp_stall, "stall", 64'(stall), 64'(exp_stall));
            check(rty == 1'b0, "rty", 64'(rty), 64'd0);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.kind == 0) begin
                    check(!ack && !err, "suppressed_resp", {62'd0, ack, err}, 64'd0);
                end else if (e.kind == 1) begin
                    check(ack && !err, "ack", {62'd0, ack, err}, 64'd2);
                    check(dat_o == e.dat, e.rd ? "rd_data" : "wr_hold_data", dat_o, e.dat);
                    check(tgd_o == e.tg, e.rd ? "rd_tag" : "wr_hold_tag", 64'(tgd_o), 64'(e.tg));
                    $display("resp ack %s adr=0x%08h dat_o=0x%016h tgd_o=%0d",
                             e.rd ? "rd" : "wr", e.adr, dat_o, tgd_o);
                end else begin
                    check(err && !ack, "err", {62'd0, ack, err}, 64'd1);
                    check(dat_o == e.dat, "err_hold_data", dat_o, e.dat);
                    $display("resp err adr=0x%08h", e.adr);
                end
            end else begin
                check(!ack && !err, "no_resp", {62'd0, ack, err}, 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] s,
                         input logic [63:0] d, input logic t, input bit suppress);
        exp_t e;
        int   waited;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a;
        sel   = s;
        dat_i = d;
        tgd_i = t;
        tga   = 1'($urandom);
        tgc   = 1'($urandom);
        lock  = 1'($urandom);
        waited = 0;
        @(negedge clk);
        while (stall && waited < 8) begin
            waited++;
            n_stalls++;
            @(negedge clk);
        end
        check(waited < 8, "stall_timeout", 64'(waited), 64'd8);
        @(posedge clk);
        #1;
        e.rd  = !w;
        e.adr = a;
        if (a < 32'd128) begin
            int word;
            word = int'(a / 8);
            e.kind = 1;
            if (w) begin
                for (int i = 0; i < 8; i++)
                    if (s[i]) mem_m[word][i*8 +: 8] = d[i*8 +: 8];
                if (s != 8'd0) tag_m[word] = t;
            end else begin
                last_dat = mem_m[word];
                last_tg  = tag_m[word];
            end
        end else begin
            e.kind = 2;
        end
        e.dat = last_dat;
        e.tg  = last_tg;
        if (suppress) e.kind = 0;
        exp_q.push_back(e);
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_cycle();
        idle(1);
        cyc = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check(dat_o == 64'd0, "reset_dat_o", dat_o, 64'd0);
        check(tgd_o == 1'b0, "reset_tgd_o", 64'(tgd_o), 64'd0);
        check(!ack && !err, "reset_ack_err", {62'd0, ack, err}, 64'd0);
        check(stall == 1'b0, "reset_stall", 64'(stall), 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence
        issue(1'b0, 32'h10, 8'hFF, 64'd0, 1'b0, 1'b0);
        end_cycle();
        issue(1'b1, 32'h08, 8'hFF, 64'h1122334455667788, 1'b1, 1'b0);
        issue(1'b0, 32'h08, 8'h00, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 32'h08, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0);
        issue(1'b0, 32'h0C, 8'h00, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 32'h80, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1, 1'b0);
        issue(1'b0, 32'h00, 8'hFF, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 32'h18, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
        end_cycle();

        // Pipelined burst of four reads
        issue(1'b1, 32'h10, 8'hF0, 64'h0123456789ABCDEF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(1'b0, 32'(i * 8), 8'h00, 64'd0, 1'b0, 1'b0);
        end_cycle();

        // Write whose response cycle has cyc dropped: no ack, write still lands
        issue(1'b1, 32'h20, 8'hFF, 64'hCAFEF00DCAFEF00D, 1'b1, 1'b1);
        cyc = 1'b0;
        idle(1);
        issue(1'b0, 32'h20, 8'h00, 64'd0, 1'b0, 1'b0);
        end_cycle();

        // Reset while a read response is pending
        issue(1'b0, 32'h00, 8'h00, 64'd0, 1'b0, 1'b0);
        issue(1'b0, 32'h08, 8'h00, 64'd0, 1'b0, 1'b1);
        rst_i = 1'b1;
        cyc   = 1'b0;
        model_reset();
        idle(2);
        rst_i = 1'b0;
        idle(1);
        issue(1'b0, 32'h08, 8'h00, 64'd0, 1'b0, 1'b0);
        end_cycle();

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic        w;
            if ($urandom_range(7) == 0)
                a = 32'h80 + 32'($urandom_range(32'h7FFF));
            else
                a = 32'($urandom_range(127));
            w = 1'($urandom);
            issue(w, a, 8'($urandom), {$urandom, $urandom}, 1'($urandom), 1'b0);
            case ($urandom_range(7))
                0: idle(1);
                1: end_cycle();
                default: ;
            endcase
        end
        end_cycle();

`ifdef WB_STALL_INJECT_EN
        check(n_stalls > 0, "stall_seen", 64'(n_stalls), 64'd1);
`endif
        check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
